// File: rtl/lsh_pkg.sv
// Shared types and constants for the streaming k-mer hasher and LSH bucket path.
// revcomp() is used only when the CANONICAL_EN macro is defined.
package lsh_pkg;

  typedef logic [1:0] base_t;

  localparam base_t BASE_A = 2'b00;
  localparam base_t BASE_C = 2'b01;
  localparam base_t BASE_G = 2'b10;
  localparam base_t BASE_T = 2'b11;

  localparam int unsigned KMER_MAX   = 32;
  localparam int unsigned KMER_MAX_W = 2 * KMER_MAX;

  localparam logic [31:0] MULT = 32'h9E37_79B1;

  localparam logic [31:0] SEED [0:3] = '{
    32'h0000_0000,
    32'h85EB_CA6B,
    32'hC2B2_AE35,
    32'h27D4_EB2F
  };

  // Reverse complement of a k-base packed k-mer (oldest base at MSBs). A<->T and C<->G
  // are bitwise inverses. Bits above 2*k come back as zero.
  function automatic logic [KMER_MAX_W-1:0] revcomp(input logic [KMER_MAX_W-1:0] kmer,
                                                    input int unsigned          k);
    logic [KMER_MAX_W-1:0] rc;
    rc = '0;
    for (int unsigned i = 0; i < KMER_MAX; i++) begin
      if (i < k) begin
        rc[2*(k-1-i) +: 2] = ~kmer[2*i +: 2];
      end
    end
    return rc;
  endfunction

endpackage

// File: rtl/kmer_hash_core.sv
// Combinational fold + multiplicative mix for one hash seed.
// Produces the 32-bit h1 and its top BW bits as the bucket index.
module kmer_hash_core
  import lsh_pkg::*;
#(
  parameter int unsigned KMER_SIZE = 16,
  parameter int unsigned BW        = 8,
  parameter logic [31:0] HASH_SEED = 32'h0
) (
  input  logic [2*KMER_SIZE-1:0] i_kmer,
  output logic [31:0]            o_h1_c,
  output logic [BW-1:0]          o_h2_c
);

  logic [31:0] w_fold;
  logic [31:0] w_mix;

  // Fold the packed k-mer down to 32 bits; short k-mers fit directly.
  generate
    if (KMER_SIZE <= 16) begin : g_short
      assign w_fold = 32'(i_kmer);
    end else begin : g_long
      assign w_fold = i_kmer[31:0] ^ 32'(i_kmer >> 32);
    end
  endgenerate

  // Seeded multiply keeps only the low 32 bits; the xor-shift spreads high bits down.
  assign w_mix  = (w_fold ^ HASH_SEED) * MULT;
  assign o_h1_c = w_mix ^ (w_mix >> 16);
  assign o_h2_c = o_h1_c[31 -: BW];

endmodule

// File: rtl/kmer_stream_hasher.sv
// Streaming k-mer hasher: one 2-bit base per cycle into a rolling window, one set of
// NUM_HASHES (h1, bucket) pairs per complete k-mer. Window register, S1 capture and
// S2 output register all advance together under a single valid/ready stall.
// Optional feature: define CANONICAL_EN to hash min(kmer, revcomp(kmer)) instead of
// the forward strand.
module kmer_stream_hasher
  import lsh_pkg::*;
#(
  parameter int unsigned KMER_SIZE   = 16,
  parameter int unsigned NUM_BUCKETS = 256,
  parameter int unsigned NUM_HASHES  = 2,
  parameter int unsigned POS_W       = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [1:0]                                in_base,
  input  logic                                      in_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [32*NUM_HASHES-1:0]                  out_h1,
  output logic [$clog2(NUM_BUCKETS)*NUM_HASHES-1:0] out_h2,
  output logic [POS_W-1:0]                          out_pos,
  output logic                                      out_last
);

  localparam int unsigned BW     = $clog2(NUM_BUCKETS);
  localparam int unsigned KW     = 2 * KMER_SIZE;
  localparam int unsigned FILL_W = $clog2(KMER_SIZE + 1);
  localparam int unsigned H1_W   = 32 * NUM_HASHES;
  localparam int unsigned H2_W   = BW * NUM_HASHES;

  logic              w_adv;
  logic              w_accept;
  logic              w_complete;
  logic [KW-1:0]     w_window_next;
  logic [FILL_W-1:0] w_fill_next;
  logic [POS_W-1:0]  w_start_pos;
  logic [KW-1:0]     w_s1_kmer;
  logic [H1_W-1:0]   w_h1;
  logic [H2_W-1:0]   w_h2;

  // Window stage
  logic [KW-1:0]     r_window;
  logic [FILL_W-1:0] r_fill;
  logic [POS_W-1:0]  r_base_idx;
  logic              r_w_valid;
  logic [POS_W-1:0]  r_w_pos;
  logic              r_w_last;

  // S1 capture stage
  logic              r_s1_valid;
  logic [KW-1:0]     r_s1_kmer;
  logic [POS_W-1:0]  r_s1_pos;
  logic              r_s1_last;

  // S2 output stage
  logic              r_out_valid;
  logic [H1_W-1:0]   r_out_h1;
  logic [H2_W-1:0]   r_out_h2;
  logic [POS_W-1:0]  r_out_pos;
  logic              r_out_last;

  // Whole pipe moves only when the output slot is free or being taken.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv && !rst;
  assign w_accept = in_valid && in_ready;

  // New base enters at the LSBs; the oldest base falls off the top.
  assign w_window_next = KW'({r_window, in_base});
  assign w_fill_next   = (r_fill == FILL_W'(KMER_SIZE)) ? r_fill : r_fill + FILL_W'(1);
  assign w_complete    = (w_fill_next == FILL_W'(KMER_SIZE));
  // r_base_idx is the index of the base being accepted; the k-mer started K-1 bases earlier.
  assign w_start_pos   = r_base_idx - POS_W'(KMER_SIZE - 1);

  // Rolling window, fill and position tracking; flags a complete k-mer for S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_window   <= '0;
      r_fill     <= '0;
      r_base_idx <= '0;
      r_w_valid  <= 1'b0;
      r_w_pos    <= '0;
      r_w_last   <= 1'b0;
    end else if (w_adv) begin
      r_w_valid <= w_accept && w_complete;
      r_w_pos   <= w_start_pos;
      r_w_last  <= in_last;
      if (w_accept) begin
        r_window <= w_window_next;
        if (in_last) begin
          r_fill     <= '0;
          r_base_idx <= '0;
        end else begin
          r_fill     <= w_fill_next;
          r_base_idx <= r_base_idx + POS_W'(1);
        end
      end
    end
  end

`ifdef CANONICAL_EN
  logic [KW-1:0] w_rc;

  // Canonical form: the smaller of forward and reverse-complement strands.
  assign w_rc      = KW'(revcomp(KMER_MAX_W'(r_window), KMER_SIZE));
  assign w_s1_kmer = (w_rc < r_window) ? w_rc : r_window;
`else
  assign w_s1_kmer = r_window;
`endif

  // S1: capture the k-mer to be hashed along with its position and last flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_kmer  <= '0;
      r_s1_pos   <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= r_w_valid;
      if (r_w_valid) begin
        r_s1_kmer <= w_s1_kmer;
        r_s1_pos  <= r_w_pos;
        r_s1_last <= r_w_last;
      end
    end
  end

  // One hash core per seed, all fed from the S1 k-mer.
  generate
    for (genvar h = 0; h < NUM_HASHES; h++) begin : g_hash
      kmer_hash_core #(
        .KMER_SIZE (KMER_SIZE),
        .BW        (BW),
        .HASH_SEED (SEED[h])
      ) u_core (
        .i_kmer (r_s1_kmer),
        .o_h1_c (w_h1[32*h +: 32]),
        .o_h2_c (w_h2[BW*h +: BW])
      );
    end
  endgenerate

  // S2: output register; holds its contents while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_h1    <= '0;
      r_out_h2    <= '0;
      r_out_pos   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_h1   <= w_h1;
        r_out_h2   <= w_h2;
        r_out_pos  <= r_s1_pos;
        r_out_last <= r_s1_last;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_h1    = r_out_h1;
  assign out_h2    = r_out_h2;
  assign out_pos   = r_out_pos;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_kmer_stream_hasher.sv
// Self-checking bench for kmer_stream_hasher (K=16, 256 buckets, 2 hashes).
// Honours CANONICAL_EN in its reference model and expected constants.
module tb_kmer_stream_hasher;

  localparam int unsigned K  = 16;
  localparam int unsigned NB = 256;
  localparam int unsigned NH = 2;
  localparam int unsigned PW = 16;
  localparam int unsigned BW = 8;

  localparam logic [31:0] T_MULT      = 32'h9E37_79B1;
  localparam logic [31:0] T_SEED [0:1] = '{32'h0000_0000, 32'h85EB_CA6B};

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_base;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [32*NH-1:0] out_h1;
  logic [BW*NH-1:0] out_h2;
  logic [PW-1:0]    out_pos;
  logic             out_last;

  always #5 clk = ~clk;

  kmer_stream_hasher #(
    .KMER_SIZE   (K),
    .NUM_BUCKETS (NB),
    .NUM_HASHES  (NH),
    .POS_W       (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_base   (in_base),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_h1    (out_h1),
    .out_h2    (out_h2),
    .out_pos   (out_pos),
    .out_last  (out_last)
  );

  typedef struct packed {
    logic [63:0] h1;
    logic [15:0] h2;
    logic [15:0] pos;
    logic        last;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] seq;
    logic [31:0] h1_0;
    logic [7:0]  h2_0;
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[5];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;
  logic [31:0] m_win;
  int          m_fill;
  int          m_pos;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] canon(input logic [31:0] p);
    logic [31:0] rc;
    rc = '0;
    for (int i = 0; i < 16; i++) rc[2*(15-i) +: 2] = ~p[2*i +: 2];
    return (rc < p) ? rc : p;
  endfunction

  function automatic logic [31:0] mdl_h1(input logic [31:0] p, input int i);
    logic [31:0] k;
    logic [31:0] m;
    k = p;
`ifdef CANONICAL_EN
    k = canon(p);
`endif
    m = (k ^ T_SEED[i]) * T_MULT;
    return m ^ (m >> 16);
  endfunction

  function automatic exp_t mdl_res(input logic [31:0] p, input int pos, input logic last);
    exp_t        e;
    logic [31:0] a;
    logic [31:0] b;
    a      = mdl_h1(p, 0);
    b      = mdl_h1(p, 1);
    e.h1   = {b, a};
    e.h2   = {b[31:24], a[31:24]};
    e.pos  = 16'(pos);
    e.last = last;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one base, wait (bounded) for acceptance, and update the reference window.
  task automatic send(input logic [1:0] b, input logic last);
    int g;
    g        = 0;
    in_valid = 1'b1;
    in_base  = b;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      chk("send_timeout", 64'(in_ready), 64'(1));
    end else begin
      @(posedge clk);
      #1;
      m_win = {m_win[29:0], b};
      if (m_fill < int'(K)) m_fill++;
      if (m_fill == int'(K)) q.push_back(mdl_res(m_win, (m_pos - int'(K) + 1) & 32'hFFFF, last));
      if (last) begin
        m_fill = 0;
        m_pos  = 0;
      end else begin
        m_pos++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_base  = 2'b00;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    step();
    rst    = 1'b0;
    q.delete();
    m_win  = '0;
    m_fill = 0;
    m_pos  = 0;
    step();
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((q.size() != 0 || out_valid) && g < 200) begin
      step();
      g++;
    end
    chk(name, 64'(q.size()), 64'(0));
  endtask

  // Scoreboard and protocol watcher, sampled on the falling edge.
  task automatic monitor();
    logic stall;
    exp_t snap;
    exp_t e;
    stall = 1'b0;
    snap  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
        if (stall) begin
          chk("hold_valid", 64'(out_valid), 64'(1));
          chk("hold_h1", out_h1, snap.h1);
          chk("hold_meta", 64'({out_h2, out_pos, out_last}), 64'({snap.h2, snap.pos, snap.last}));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 64'(out_valid), 64'(0));
          end else begin
            e = q.pop_front();
            n_pop++;
            chk("sb_h1", out_h1, e.h1);
            chk("sb_h2", 64'(out_h2), 64'(e.h2));
            chk("sb_pos", 64'(out_pos), 64'(e.pos));
            chk("sb_last", 64'(out_last), 64'(e.last));
          end
        end
        stall     = out_valid && !out_ready;
        snap.h1   = out_h1;
        snap.h2   = out_h2;
        snap.pos  = out_pos;
        snap.last = out_last;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_base   = 2'b00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    m_win     = '0;
    m_fill    = 0;
    m_pos     = 0;

    fork
      monitor();
    join_none

    // All-A folds to zero with seed 0; all-T is hand-computed: -MULT = 0x61C8864F,
    // xor-shift gives 0x61C8E787. Canonical all-T collapses to all-A.
    vecs[0] = '{"allA", 32'h0000_0000, 32'h0000_0000, 8'h00};
`ifdef CANONICAL_EN
    vecs[1] = '{"allT", 32'hFFFF_FFFF, 32'h0000_0000, 8'h00};
`else
    vecs[1] = '{"allT", 32'hFFFF_FFFF, 32'h61C8_E787, 8'h61};
`endif
    vecs[2] = '{"allG", 32'hAAAA_AAAA, mdl_h1(32'hAAAA_AAAA, 0), 8'h00};
    vecs[3] = '{"acgt", 32'h1B1B_1B1B, mdl_h1(32'h1B1B_1B1B, 0), 8'h00};
    vecs[4] = '{"mix",  32'h3C5A_96E1, mdl_h1(32'h3C5A_96E1, 0), 8'h00};
    for (int v = 2; v < 5; v++) vecs[v].h2_0 = vecs[v].h1_0[31:24];

    // Reset state
    do_reset();
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_h1", out_h1, 64'(0));
    chk("reset_out_h2", 64'(out_h2), 64'(0));
    chk("reset_out_pos", 64'(out_pos), 64'(0));
    chk("reset_out_last", 64'(out_last), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));

    // Single k-mer vectors: latency and hash values
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 15; i >= 0; i--) send(vecs[v].seq[2*i +: 2], 1'b0);
      chk({vecs[v].name, "_lat0"}, 64'(out_valid), 64'(0));
      step();
      chk({vecs[v].name, "_lat1"}, 64'(out_valid), 64'(0));
      step();
      chk({vecs[v].name, "_valid"}, 64'(out_valid), 64'(1));
      chk({vecs[v].name, "_h1_0"}, 64'(out_h1[31:0]), 64'(vecs[v].h1_0));
      chk({vecs[v].name, "_h2_0"}, 64'(out_h2[7:0]), 64'(vecs[v].h2_0));
      chk({vecs[v].name, "_pos"}, 64'(out_pos), 64'(0));
      drain({vecs[v].name, "_drain"});
    end

    // 20 x G: five results on consecutive cycles, positions 0..4
    do_reset();
    fork
      begin
        for (int i = 0; i < 20; i++) send(2'b10, 1'b0);
      end
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (!out_valid && g < 100) begin
          @(negedge clk);
          g++;
        end
        for (int i = 0; i < 5; i++) begin
          chk("t2_consec", 64'(out_valid), 64'(1));
          chk("t2_pos", 64'(out_pos), 64'(i));
          @(negedge clk);
        end
        chk("t2_end", 64'(out_valid), 64'(0));
      end
    join
    drain("t2_drain");

    // Back-pressure: out_ready low 5 cycles mid-stream
    do_reset();
    p0 = n_pop;
    fork
      begin
        for (int i = 0; i < 24; i++) send(2'((i * 7 + i / 3) % 4), 1'b0);
      end
      begin
        int g;
        g = 0;
        while (!out_valid && g < 100) begin
          step();
          g++;
        end
        step();
        out_ready = 1'b0;
        step();
        chk("t3_in_ready", 64'(in_ready), 64'(0));
        repeat (4) step();
        out_ready = 1'b1;
      end
    join
    drain("t3_drain");
    chk("t3_count", 64'(n_pop - p0), 64'(9));

    // Sequence boundary: 18 bases with last, then 16 more
    do_reset();
    p0 = n_pop;
    for (int i = 0; i < 18; i++) send(2'((i * 3 + 1) % 4), 1'(i == 17));
    for (int i = 0; i < 16; i++) send(2'((i + 2) % 4), 1'b0);
    drain("t4_drain");
    chk("t4_count", 64'(n_pop - p0), 64'(4));

    // Reset with two k-mers in flight
    do_reset();
    for (int i = 0; i < 17; i++) send(2'(i % 4), 1'b0);
    chk("t6_pre", 64'(out_valid), 64'(0));
    rst = 1'b1;
    step();
    chk("t6_valid", 64'(out_valid), 64'(0));
    chk("t6_in_ready", 64'(in_ready), 64'(0));
    rst    = 1'b0;
    q.delete();
    m_win  = '0;
    m_fill = 0;
    m_pos  = 0;
    p0     = n_pop;
    repeat (6) begin
      step();
      chk("t6_quiet", 64'(out_valid), 64'(0));
    end
    chk("t6_pops", 64'(n_pop - p0), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
